int_replay_queue: RTL and testbench
===================================

Name: int_replay_queue

Overview:
- Transmitter side of the integer issue/replay interface: records groups of ops issued from the integer issue queue, and on request re-sends them to the integer issue stage.
- Re-sent groups use the replay / per-lane-valid / payload signals, one group per cycle.
- Sits beside the integer scheduler.
- Enforces selective-flush pruning, a fixed replay window, and full/empty back-pressure.

Parameters:
- ISSUE_WIDTH, 2, lanes per group.
- DEPTH, 8, group entries (power of two).
- DATA_W, 64, per-lane payload width.
- AL_PTR_W, 6, active-list pointer width.
- IQ_PTR_W, 4, issue-queue pointer width.
- REPLAY_WINDOW, 3, unstalled cycles a group stays replayable.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  stage stall; freezes enqueue, dequeue and ages
- enq_valid  in  ISSUE_WIDTH  per-lane issued-op valid
- enq_data  in  ISSUE_WIDTH*DATA_W  per-lane payload
- enq_al_ptr  in  ISSUE_WIDTH*AL_PTR_W  per-lane active-list pointer
- enq_iq_ptr  in  ISSUE_WIDTH*IQ_PTR_W  per-lane issue-queue pointer
- replay_start  in  1  pulse: replay all held groups
- flush_valid  in  1  recovery-phase selective flush
- flush_head  in  AL_PTR_W  flush range head (inclusive)
- flush_tail  in  AL_PTR_W  flush range tail (exclusive)
- flush_all  in  1  flush every op
- replay  out  1  replay group valid this cycle
- replay_entry  out  ISSUE_WIDTH  per-lane replay valid
- replay_data  out  ISSUE_WIDTH*DATA_W  replayed payload
- replay_al_ptr  out  ISSUE_WIDTH*AL_PTR_W  replayed active-list pointers
- replay_iq_ptr  out  ISSUE_WIDTH*IQ_PTR_W  replayed issue-queue pointers
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- overflow  out  1  sticky: enqueue attempted while full

Behaviour:
- Reset values: all outputs 0 except empty=1; head, tail and count = 0; FSM = IDLE. Reset mid-replay aborts immediately.
- Storage: circular buffer of groups, fields per lane {valid, data, al_ptr, iq_ptr}, one age counter per group. Pointers wrap modulo DEPTH; count is log2(DEPTH)+1 bits.
- Enqueue:
  - When !stall and |enq_valid, one group is written at tail with age=0; tail and count advance.
  - Lanes flushed in the same cycle are stored invalid.
  - If full and no same-cycle dequeue: write dropped, overflow set (sticky until rst).
  - A same-cycle dequeue frees a slot, so the write succeeds.
- Flush test per lane p:
  - flush_all → flushed.
  - else head<=tail → flushed iff head<=p<tail.
  - else → flushed iff p>=head or p<tail.
  - Only effective when flush_valid=1.
  - Clears stored valid bits at the edge and combinationally masks replay_entry in the same cycle.
- FSM IDLE:
  - Each !stall cycle, all group ages increment, saturating at REPLAY_WINDOW.
  - If head age == REPLAY_WINDOW, head is discarded; at most one per cycle, since groups arrive at most one per cycle.
  - replay_start with !empty → REPLAY next cycle.
  - replay_start when empty → ignored.
- FSM REPLAY:
  - replay = !empty.
  - Outputs are driven combinationally from head: replay_entry = head valid & ~flushed.
  - On !stall, head pops, including a group whose lanes are all invalid (replay=1, replay_entry=0).
  - Ages are frozen; replay_start is ignored.
  - Enqueues during REPLAY are appended at tail and are replayed in the same pass.
  - Return to IDLE when count reaches 0 after a pop, or at once if empty.
- Latency: replay_start at cycle t → first group on outputs at t+1.
- When replay=0: replay_data, replay_al_ptr, replay_iq_ptr and replay_entry = 0.
- stall=1: nothing advances; outputs hold the head group.

Optional Feature:
- INT_REPLAY_QUEUE_PERF_COUNTER_EN defined:
  - Adds outputs perf_replay_groups and perf_flushed_lanes, each 32 bits, wrapping.
  - They count popped groups and lanes cleared by flush; rst clears them.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Test Plan:
- Reset, then idle: replay=0, empty=1, full=0, overflow=0, all data outputs 0.
- Enqueue groups A (lanes 11), B (10), C (01) on consecutive cycles, then replay_start:
  - Next 3 cycles: replay=1 with replay_entry 11, 10, 01 and matching payloads.
  - Then replay=0 and empty=1.
- Enqueue one group, wait 3 unstalled cycles → empty=1; a later replay_start produces no replay.
- Hold stall=1 for 5 cycles after enqueue → group still held; replay_start then replays it.
- Fill 8 groups, enqueue a 9th → full=1, overflow=1, 9th dropped; during replay, a same-cycle pop+enqueue when full is accepted with no overflow change.
- Group lanes al_ptr=60,2, flush_head=58, flush_tail=1 (wrap), mid-replay → lane0 masked (replay_entry=10 for that group), lane1 kept; flush_all → replay_entry=00 but replay still 1.

Source files
------------

// File: rtl/int_replay_queue.sv
// Integer issue/replay transmitter: holds recently issued op groups and re-sends them on request.
// Optional perf counters are enabled by defining INT_REPLAY_QUEUE_PERF_COUNTER_EN.
module int_replay_queue #(
    parameter int ISSUE_WIDTH   = 2,
    parameter int DEPTH         = 8,
    parameter int DATA_W        = 64,
    parameter int AL_PTR_W      = 6,
    parameter int IQ_PTR_W      = 4,
    parameter int REPLAY_WINDOW = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            stall,
    input  logic [ISSUE_WIDTH-1:0]          enq_valid,
    input  logic [ISSUE_WIDTH*DATA_W-1:0]   enq_data,
    input  logic [ISSUE_WIDTH*AL_PTR_W-1:0] enq_al_ptr,
    input  logic [ISSUE_WIDTH*IQ_PTR_W-1:0] enq_iq_ptr,
    input  logic                            replay_start,
    input  logic                            flush_valid,
    input  logic [AL_PTR_W-1:0]             flush_head,
    input  logic [AL_PTR_W-1:0]             flush_tail,
    input  logic                            flush_all,
    output logic                            replay,
    output logic [ISSUE_WIDTH-1:0]          replay_entry,
    output logic [ISSUE_WIDTH*DATA_W-1:0]   replay_data,
    output logic [ISSUE_WIDTH*AL_PTR_W-1:0] replay_al_ptr,
    output logic [ISSUE_WIDTH*IQ_PTR_W-1:0] replay_iq_ptr,
    output logic                            full,
    output logic                            empty,
    output logic                            overflow
`ifdef INT_REPLAY_QUEUE_PERF_COUNTER_EN
    ,
    output logic [31:0]                     perf_replay_groups,
    output logic [31:0]                     perf_flushed_lanes
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int AGE_W = $clog2(REPLAY_WINDOW + 1);
    localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(REPLAY_WINDOW);

    typedef enum logic [0:0] {IDLE, REPLAY} state_t;

    state_t                          state_reg, state_next;
    logic [PTR_W-1:0]                head_reg, tail_reg;
    logic [CNT_W-1:0]                count_reg, count_next;
    logic                            overflow_reg;
    logic [ISSUE_WIDTH-1:0]          vld_reg  [DEPTH];
    logic [ISSUE_WIDTH*DATA_W-1:0]   data_reg [DEPTH];
    logic [ISSUE_WIDTH*AL_PTR_W-1:0] al_reg   [DEPTH];
    logic [ISSUE_WIDTH*IQ_PTR_W-1:0] iq_reg   [DEPTH];
    logic [AGE_W-1:0]                age_reg  [DEPTH];

    logic [DEPTH-1:0][ISSUE_WIDTH-1:0] store_flush;
    logic [ISSUE_WIDTH-1:0]            enq_flush;
    logic                              deq, enq_try, enq_ok;

    // Range is [head, tail) on the circular active-list pointer space.
    function automatic logic in_flush_range(input logic fv, input logic fa,
                                            input logic [AL_PTR_W-1:0] h,
                                            input logic [AL_PTR_W-1:0] t,
                                            input logic [AL_PTR_W-1:0] p);
        if (!fv) return 1'b0;
        if (fa) return 1'b1;
        if (h <= t) return (p >= h) && (p < t);
        return (p >= h) || (p < t);
    endfunction

    genvar gi, gl;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            for (gl = 0; gl < ISSUE_WIDTH; gl++) begin : g_lane
                assign store_flush[gi][gl] = in_flush_range(flush_valid, flush_all, flush_head,
                    flush_tail, al_reg[gi][gl*AL_PTR_W +: AL_PTR_W]);
            end
        end
        for (gl = 0; gl < ISSUE_WIDTH; gl++) begin : g_enq_lane
            assign enq_flush[gl] = in_flush_range(flush_valid, flush_all, flush_head,
                flush_tail, enq_al_ptr[gl*AL_PTR_W +: AL_PTR_W]);
        end
    endgenerate

    assign empty    = (count_reg == '0);
    assign full     = (count_reg == CNT_W'(DEPTH));
    assign overflow = overflow_reg;
    // Head leaves either by being replayed or by aging out of the window while idle.
    assign deq      = !stall && !empty &&
                      ((state_reg == REPLAY) || (age_reg[head_reg] == AGE_MAX));
    assign enq_try  = !stall && (|enq_valid);
    assign enq_ok   = enq_try && (!full || deq);
    assign count_next = count_reg + CNT_W'(enq_ok) - CNT_W'(deq);
    assign replay   = (state_reg == REPLAY) && !empty;

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (replay_start && !empty) state_next = REPLAY;
            REPLAY:  if (empty || (deq && count_next == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        replay_entry  = '0;
        replay_data   = '0;
        replay_al_ptr = '0;
        replay_iq_ptr = '0;
        if (replay) begin
            replay_entry  = vld_reg[head_reg] & ~store_flush[head_reg];
            replay_data   = data_reg[head_reg];
            replay_al_ptr = al_reg[head_reg];
            replay_iq_ptr = iq_reg[head_reg];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            head_reg     <= '0;
            tail_reg     <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                vld_reg[i] <= '0;
                age_reg[i] <= '0;
            end
        end else begin
            state_reg <= state_next;
            for (int i = 0; i < DEPTH; i++) begin
                vld_reg[i] <= vld_reg[i] & ~store_flush[i];
                if (state_reg == IDLE && !stall && age_reg[i] != AGE_MAX)
                    age_reg[i] <= age_reg[i] + 1'b1;
            end
            if (enq_ok) begin
                vld_reg[tail_reg] <= enq_valid & ~enq_flush;
                age_reg[tail_reg] <= '0;
                tail_reg          <= tail_reg + 1'b1;
            end
            if (deq) head_reg <= head_reg + 1'b1;
            count_reg <= count_next;
            if (enq_try && full && !deq) overflow_reg <= 1'b1;
        end
    end

    // Payload fields carry no reset; validity lives in vld_reg.
    always_ff @(posedge clk) begin
        if (enq_ok) begin
            data_reg[tail_reg] <= enq_data;
            al_reg[tail_reg]   <= enq_al_ptr;
            iq_reg[tail_reg]   <= enq_iq_ptr;
        end
    end

`ifdef INT_REPLAY_QUEUE_PERF_COUNTER_EN
    logic [DEPTH-1:0] occ;
    logic [31:0]      flushed_now;

    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_occ
            logic [PTR_W-1:0] off;
            assign off     = PTR_W'(gi) - head_reg;
            assign occ[gi] = {1'b0, off} < count_reg;
        end
    endgenerate

    always_comb begin
        flushed_now = '0;
        for (int i = 0; i < DEPTH; i++)
            for (int l = 0; l < ISSUE_WIDTH; l++)
                if (occ[i] && vld_reg[i][l] && store_flush[i][l])
                    flushed_now = flushed_now + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_replay_groups <= '0;
            perf_flushed_lanes <= '0;
        end else begin
            if (deq && state_reg == REPLAY) perf_replay_groups <= perf_replay_groups + 32'd1;
            perf_flushed_lanes <= perf_flushed_lanes + flushed_now;
        end
    end
`endif

endmodule

// File: tb/tb_int_replay_queue.sv
// Scoreboard bench for int_replay_queue: a default instance plus a long-window instance for fill/overflow.
module tb_int_replay_queue;

    typedef struct {
        logic [1:0]   entry;
        logic [127:0] data;
        logic [11:0]  al;
        logic [7:0]   iq;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, stall, replay_start, flush_valid, flush_all;
    logic [1:0]   enq_valid;
    logic [127:0] enq_data;
    logic [11:0]  enq_al_ptr;
    logic [7:0]   enq_iq_ptr;
    logic [5:0]   flush_head, flush_tail;
    logic         replay, full, empty, overflow;
    logic [1:0]   replay_entry;
    logic [127:0] replay_data;
    logic [11:0]  replay_al_ptr;
    logic [7:0]   replay_iq_ptr;

    logic         d_replay_start, d_replay, d_full, d_empty, d_overflow;
    logic [1:0]   d_enq_valid, d_replay_entry;
    logic [127:0] d_replay_data;
    logic [11:0]  d_replay_al_ptr;
    logic [7:0]   d_replay_iq_ptr;

`ifdef INT_REPLAY_QUEUE_PERF_COUNTER_EN
    logic [31:0] perf_g, perf_f, d_perf_g, d_perf_f;
`endif

    int vectors = 0;
    int miscompares = 0;
    exp_t q[$];
    exp_t dq[$];

    int_replay_queue dut (
        .clk(clk), .rst(rst), .stall(stall), .enq_valid(enq_valid), .enq_data(enq_data),
        .enq_al_ptr(enq_al_ptr), .enq_iq_ptr(enq_iq_ptr), .replay_start(replay_start),
        .flush_valid(flush_valid), .flush_head(flush_head), .flush_tail(flush_tail),
        .flush_all(flush_all), .replay(replay), .replay_entry(replay_entry),
        .replay_data(replay_data), .replay_al_ptr(replay_al_ptr), .replay_iq_ptr(replay_iq_ptr),
        .full(full), .empty(empty), .overflow(overflow)
`ifdef INT_REPLAY_QUEUE_PERF_COUNTER_EN
        , .perf_replay_groups(perf_g), .perf_flushed_lanes(perf_f)
`endif
    );

    // Window long enough that eight groups can be held at once.
    int_replay_queue #(.REPLAY_WINDOW(15)) u_deep (
        .clk(clk), .rst(rst), .stall(stall), .enq_valid(d_enq_valid), .enq_data(enq_data),
        .enq_al_ptr(enq_al_ptr), .enq_iq_ptr(enq_iq_ptr), .replay_start(d_replay_start),
        .flush_valid(flush_valid), .flush_head(flush_head), .flush_tail(flush_tail),
        .flush_all(flush_all), .replay(d_replay), .replay_entry(d_replay_entry),
        .replay_data(d_replay_data), .replay_al_ptr(d_replay_al_ptr),
        .replay_iq_ptr(d_replay_iq_ptr), .full(d_full), .empty(d_empty), .overflow(d_overflow)
`ifdef INT_REPLAY_QUEUE_PERF_COUNTER_EN
        , .perf_replay_groups(d_perf_g), .perf_flushed_lanes(d_perf_f)
`endif
    );

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic exp_t mk(input logic [1:0] e, input logic [63:0] d0, input logic [63:0] d1,
                                input logic [5:0] a0, input logic [5:0] a1,
                                input logic [3:0] i0, input logic [3:0] i1);
        exp_t r;
        r.entry = e;
        r.data  = {d1, d0};
        r.al    = {a1, a0};
        r.iq    = {i1, i0};
        return r;
    endfunction

    task automatic payload(input logic [63:0] d0, input logic [63:0] d1,
                           input logic [5:0] a0, input logic [5:0] a1,
                           input logic [3:0] i0, input logic [3:0] i1);
        enq_data   = {d1, d0};
        enq_al_ptr = {a1, a0};
        enq_iq_ptr = {i1, i0};
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitors: one popped group per unstalled replay cycle.
    always @(negedge clk) begin
        if (!rst && !stall && replay === 1'b1) begin
            if (q.size() == 0) begin
                check("main_unexpected_replay", 160'(replay_entry), 160'(2'b00));
                vectors++;
                miscompares++;
                $display("FAIL main_unexpected_replay: got replay=1 want replay=0");
            end else begin
                exp_t e;
                e = q.pop_front();
                $display("main replay: entry=%b al=%h iq=%h data=%h", replay_entry,
                         replay_al_ptr, replay_iq_ptr, replay_data);
                check("main_replay_group", {replay_entry, replay_data, replay_al_ptr, replay_iq_ptr},
                      {e.entry, e.data, e.al, e.iq});
            end
        end
        if (!rst && !stall && d_replay === 1'b1) begin
            if (dq.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL deep_unexpected_replay: got replay=1 want replay=0");
            end else begin
                exp_t e;
                e = dq.pop_front();
                $display("deep replay: entry=%b al=%h iq=%h data=%h", d_replay_entry,
                         d_replay_al_ptr, d_replay_iq_ptr, d_replay_data);
                check("deep_replay_group",
                      {d_replay_entry, d_replay_data, d_replay_al_ptr, d_replay_iq_ptr},
                      {e.entry, e.data, e.al, e.iq});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; stall = 1'b0; enq_valid = '0; d_enq_valid = '0;
        replay_start = 1'b0; d_replay_start = 1'b0;
        flush_valid = 1'b0; flush_all = 1'b0; flush_head = '0; flush_tail = '0;
        payload(64'h0, 64'h0, 6'd0, 6'd0, 4'd0, 4'd0);
        tick(); tick();
        rst = 1'b0;

        // Reset / idle state
        check("rst_replay", 160'(replay), 160'(0));
        check("rst_empty", 160'(empty), 160'(1));
        check("rst_full", 160'(full), 160'(0));
        check("rst_overflow", 160'(overflow), 160'(0));
        check("rst_entry", 160'(replay_entry), 160'(0));
        check("rst_data", 160'(replay_data), 160'(0));
        check("rst_ptrs", 160'({replay_al_ptr, replay_iq_ptr}), 160'(0));
        check("rst_deep_empty", 160'(d_empty), 160'(1));
        tick();
        check("idle_replay", 160'(replay), 160'(0));

        // A, B, C then replay
        enq_valid = 2'b11; payload(64'hA0, 64'hA1, 6'd1, 6'd2, 4'd1, 4'd2); tick();
        enq_valid = 2'b10; payload(64'hB0, 64'hB1, 6'd3, 6'd4, 4'd3, 4'd4); tick();
        enq_valid = 2'b01; payload(64'hC0, 64'hC1, 6'd5, 6'd6, 4'd5, 4'd6); tick();
        enq_valid = 2'b00;
        check("abc_not_empty", 160'(empty), 160'(0));
        q.push_back(mk(2'b11, 64'hA0, 64'hA1, 6'd1, 6'd2, 4'd1, 4'd2));
        q.push_back(mk(2'b10, 64'hB0, 64'hB1, 6'd3, 6'd4, 4'd3, 4'd4));
        q.push_back(mk(2'b01, 64'hC0, 64'hC1, 6'd5, 6'd6, 4'd5, 4'd6));
        replay_start = 1'b1; tick(); replay_start = 1'b0;
        tick(); tick(); tick();
        check("abc_done_empty", 160'(empty), 160'(1));
        check("abc_done_replay", 160'(replay), 160'(0));
        check("abc_done_data", 160'(replay_data), 160'(0));

        // Window expiry
        enq_valid = 2'b11; payload(64'hD0, 64'hD1, 6'd7, 6'd8, 4'd7, 4'd8); tick();
        enq_valid = 2'b00;
        tick();
        check("win_held", 160'(empty), 160'(0));
        tick(); tick(); tick(); tick();
        check("win_expired", 160'(empty), 160'(1));
        replay_start = 1'b1; tick(); replay_start = 1'b0;
        check("win_no_replay", 160'(replay), 160'(0));
        tick();
        check("win_no_replay2", 160'(replay), 160'(0));

        // Stall freezes ageing
        enq_valid = 2'b11; payload(64'hE0, 64'hE1, 6'd9, 6'd10, 4'd9, 4'd10); tick();
        enq_valid = 2'b00;
        stall = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        stall = 1'b0;
        check("stall_held", 160'(empty), 160'(0));
        q.push_back(mk(2'b11, 64'hE0, 64'hE1, 6'd9, 6'd10, 4'd9, 4'd10));
        replay_start = 1'b1; tick(); replay_start = 1'b0;
        tick();
        check("stall_done_empty", 160'(empty), 160'(1));

        // Flush during replay: wrapping range, then flush_all
        enq_valid = 2'b11; payload(64'h50, 64'h51, 6'd60, 6'd2, 4'd1, 4'd2); tick();
        enq_valid = 2'b11; payload(64'h60, 64'h61, 6'd10, 6'd20, 4'd3, 4'd4); tick();
        enq_valid = 2'b00;
        q.push_back(mk(2'b10, 64'h50, 64'h51, 6'd60, 6'd2, 4'd1, 4'd2));
        q.push_back(mk(2'b00, 64'h60, 64'h61, 6'd10, 6'd20, 4'd3, 4'd4));
        replay_start = 1'b1; tick(); replay_start = 1'b0;
        flush_valid = 1'b1; flush_head = 6'd58; flush_tail = 6'd1;
        tick();
        flush_all = 1'b1;
        check("flushall_replay_high", 160'(replay), 160'(1));
        tick();
        flush_valid = 1'b0; flush_all = 1'b0;
        check("flush_done_empty", 160'(empty), 160'(1));

        // Flush of stored lanes and of a same-cycle enqueue
        enq_valid = 2'b11; payload(64'h70, 64'h71, 6'd5, 6'd40, 4'd5, 4'd6); tick();
        enq_valid = 2'b11; payload(64'h80, 64'h81, 6'd33, 6'd7, 4'd7, 4'd8);
        flush_valid = 1'b1; flush_head = 6'd30; flush_tail = 6'd50; tick();
        enq_valid = 2'b00; flush_valid = 1'b0;
        q.push_back(mk(2'b01, 64'h70, 64'h71, 6'd5, 6'd40, 4'd5, 4'd6));
        q.push_back(mk(2'b10, 64'h80, 64'h81, 6'd33, 6'd7, 4'd7, 4'd8));
        replay_start = 1'b1; tick(); replay_start = 1'b0;
        tick(); tick();
        check("sflush_done_empty", 160'(empty), 160'(1));

        // Fill, overflow, and full-queue enqueue with same-cycle pop
        for (int i = 0; i < 8; i++) begin
            d_enq_valid = 2'b11;
            payload(64'h1000 + 64'(i), 64'h2000 + 64'(i), 6'(i), 6'(i + 20), 4'(i), 4'(15 - i));
            tick();
        end
        d_enq_valid = 2'b00;
        check("fill_full", 160'(d_full), 160'(1));
        check("fill_no_overflow", 160'(d_overflow), 160'(0));
        d_enq_valid = 2'b11; payload(64'hDEAD, 64'hBEEF, 6'd63, 6'd63, 4'd15, 4'd15); tick();
        d_enq_valid = 2'b00;
        check("ovf_set", 160'(d_overflow), 160'(1));
        check("ovf_still_full", 160'(d_full), 160'(1));
        for (int i = 0; i < 9; i++)
            dq.push_back(mk(2'b11, 64'h1000 + 64'(i), 64'h2000 + 64'(i), 6'(i), 6'(i + 20),
                            4'(i), 4'(15 - i)));
        d_replay_start = 1'b1; tick(); d_replay_start = 1'b0;
        d_enq_valid = 2'b11; payload(64'h1008, 64'h2008, 6'd8, 6'd28, 4'd8, 4'd7); tick();
        d_enq_valid = 2'b00;
        check("popenq_full", 160'(d_full), 160'(1));
        check("popenq_overflow_sticky", 160'(d_overflow), 160'(1));
        for (int i = 0; i < 8; i++) tick();
        check("deep_done_empty", 160'(d_empty), 160'(1));
        check("deep_done_replay", 160'(d_replay), 160'(0));

        tick();
        check("main_sb_drained", 160'(q.size()), 160'(0));
        check("deep_sb_drained", 160'(dq.size()), 160'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
